mem_access_stage: RTL and testbench

- Memory stage placed between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Drives a multi-cycle data memory over a req/ack handshake.
- Returns load data for the MEM/WB register.
- Forwards WB-stage results into store data (MEM-to-MEM forwarding).
- Asserts a pipeline stall while any access is outstanding.

---
 rtl/mem_access_stage.sv | 120 ++++++++++++
 tb/tb_mem_access_stage.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// Memory access stage between EX/MEM and MEM/WB: drives a req/ack data memory,
// forwards WB results into store data, and stalls the pipeline while an access is outstanding.
module mem_access_stage #(
    parameter int DATA_WIDTH = 16,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic                  in_mem_read,
    input  logic                  in_mem_write,
    input  logic                  in_halt,
    input  logic [3:0]            in_src_reg2,
    input  logic [DATA_WIDTH-1:0] in_alu_out,
    input  logic [DATA_WIDTH-1:0] in_store_data,
    input  logic                  wb_write_reg,
    input  logic [3:0]            wb_dst_reg,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] out_mem_data,
    output logic                  stall,
    output logic                  fwd_used,
    output logic                  mem_err
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  req_q;
    logic                  we_q;
    logic                  fwd_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic                  access;
    logic                  fwd_hit;
    logic [DATA_WIDTH-1:0] store_sel;

    assign access    = in_valid & (in_mem_read | in_mem_write) & ~in_halt;
    // r0 is hard-wired zero, so a WB write to r0 must never be forwarded
    assign fwd_hit   = wb_write_reg & (wb_dst_reg == in_src_reg2) & (wb_dst_reg != 4'd0);
    assign store_sel = fwd_hit ? wb_data : in_store_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            fwd_q   <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (access) begin
                        state_q <= REQ;
                        req_q   <= 1'b1;
                        we_q    <= in_mem_write;
                        addr_q  <= in_alu_out;
                        wdata_q <= store_sel;
                        fwd_q   <= fwd_hit;
                        cnt_q   <= '0;
                    end else begin
                        fwd_q   <= 1'b0;
                    end
                end
                REQ: begin
                    cnt_q <= cnt_q + 1'b1;
                    // ack takes priority over a timeout landing in the same cycle
                    if (mem_ack) begin
                        if (!we_q) begin
                            rdata_q <= mem_rdata;
                        end
                        req_q   <= 1'b0;
                        state_q <= DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                        req_q   <= 1'b0;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Stall is combinational in IDLE so a new access freezes the pipe with zero delay
    assign stall        = rst & (((state_q == IDLE) & access) | (state_q == REQ));
    assign mem_req      = req_q;
    assign mem_we       = we_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign out_mem_data = rdata_q;
    assign fwd_used     = fwd_q;
    assign mem_err      = err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: per-cycle expectations derived from the
// instruction-level rules, plus literal checks on latencies and captured data.
module tb_mem_access_stage;
    localparam int DW = 16;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0, in_mem_read = 1'b0, in_mem_write = 1'b0, in_halt = 1'b0;
    logic [3:0]    in_src_reg2 = 4'd0;
    logic [DW-1:0] in_alu_out = '0, in_store_data = '0;
    logic          wb_write_reg = 1'b0;
    logic [3:0]    wb_dst_reg = 4'd0;
    logic [DW-1:0] wb_data = '0;
    logic          mem_req, mem_we;
    logic [DW-1:0] mem_addr, mem_wdata;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic [DW-1:0] out_mem_data;
    logic          stall, fwd_used, mem_err;

    mem_access_stage #(.DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
        .in_halt(in_halt), .in_src_reg2(in_src_reg2), .in_alu_out(in_alu_out),
        .in_store_data(in_store_data), .wb_write_reg(wb_write_reg), .wb_dst_reg(wb_dst_reg),
        .wb_data(wb_data), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .out_mem_data(out_mem_data), .stall(stall), .fwd_used(fwd_used), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;
    int stall_cnt = 0;
    int req_cnt = 0;
    logic chk_en = 1'b0;

    // Architectural view of the stage's held outputs
    logic          h_we = 1'b0, h_fwd = 1'b0, h_err = 1'b0;
    logic [DW-1:0] h_addr = '0, h_wdata = '0, h_out = '0;

    logic          exp_stall = 1'b0, exp_req = 1'b0, exp_we = 1'b0, exp_fwd = 1'b0, exp_err = 1'b0;
    logic [DW-1:0] exp_addr = '0, exp_wdata = '0, exp_out = '0;

    // MEM/WB register model: advances only when not stalled
    logic [DW-1:0] memwb_q = '0;
    always @(posedge clk) if (!stall) memwb_q <= out_mem_data;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("stall", 16'(stall), 16'(exp_stall));
            check("mem_req", 16'(mem_req), 16'(exp_req));
            check("mem_we", 16'(mem_we), 16'(exp_we));
            check("mem_addr", mem_addr, exp_addr);
            check("mem_wdata", mem_wdata, exp_wdata);
            check("out_mem_data", out_mem_data, exp_out);
            check("fwd_used", 16'(fwd_used), 16'(exp_fwd));
            check("mem_err", 16'(mem_err), 16'(exp_err));
        end
    end

    task automatic set_exp(input logic s, input logic r);
        exp_stall = s;      exp_req   = r;
        exp_we    = h_we;   exp_addr  = h_addr;
        exp_wdata = h_wdata; exp_out  = h_out;
        exp_fwd   = h_fwd;  exp_err   = h_err;
    endtask

    task automatic step();
        @(negedge clk);
        if (stall) stall_cnt++;
        if (mem_req) req_cnt++;
        @(posedge clk);
        #1;
    endtask

    // One instruction through the stage. ack_d = REQ cycle index of the ack, -1 = never.
    task automatic run_instr(input string name, input logic v, input logic rd, input logic wr,
                             input logic hlt, input logic [3:0] src, input logic [DW-1:0] addr,
                             input logic [DW-1:0] sd, input int ack_d, input logic [DW-1:0] rdata,
                             input logic scramble, input logic stray);
        logic acc, fw, err;
        logic [DW-1:0] sel;
        int n;
        stall_cnt = 0;
        req_cnt   = 0;
        in_valid = v; in_mem_read = rd; in_mem_write = wr; in_halt = hlt;
        in_src_reg2 = src; in_alu_out = addr; in_store_data = sd;
        acc = v && (rd || wr) && !hlt;
        fw  = wb_write_reg && (wb_dst_reg == src) && (wb_dst_reg != 4'd0);
        sel = fw ? wb_data : sd;
        mem_ack   = stray && !acc;
        mem_rdata = 16'hDEAD;
        set_exp(acc, 1'b0);
        step();
        mem_ack = 1'b0;
        if (!acc) begin
            h_fwd = 1'b0;
        end else begin
            h_addr = addr; h_we = wr; h_wdata = sel; h_fwd = fw;
            err = (ack_d < 0) || (ack_d > TO - 1);
            n   = err ? TO : ack_d + 1;
            for (int k = 0; k < n; k++) begin
                set_exp(1'b1, 1'b1);
                mem_ack   = !err && (k == ack_d);
                mem_rdata = mem_ack ? rdata : 16'hDEAD;
                if (scramble) begin
                    in_alu_out    = 16'($urandom);
                    in_store_data = 16'($urandom);
                    in_mem_write  = ~in_mem_write;
                    in_src_reg2   = 4'($urandom);
                end
                step();
            end
            if (err) h_out = '0;
            else if (!wr) h_out = rdata;
            h_err = h_err | err;
            mem_ack   = stray;
            mem_rdata = 16'hDEAD;
            set_exp(1'b0, 1'b0);
            step();
            mem_ack = 1'b0;
        end
        $display("[TB] %s: stall %0d cycles, mem_req %0d cycles, out_mem_data %h",
                 name, stall_cnt, req_cnt, out_mem_data);
    endtask

    initial begin
        #3;
        check("rst_stall", 16'(stall), 16'd0);
        check("rst_req", 16'(mem_req), 16'd0);
        check("rst_addr", mem_addr, 16'h0000);
        check("rst_out", out_mem_data, 16'h0000);
        check("rst_err_fwd_we", {13'd0, mem_err, fwd_used, mem_we}, 16'd0);
        #9 rst = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b1;

        run_instr("load 0040", 1, 1, 0, 0, 4'd1, 16'h0040, 16'h0000, 0, 16'hBEEF, 0, 0);
        check("load_stall_cycles", 16'(stall_cnt), 16'd2);
        check("load_req_cycles", 16'(req_cnt), 16'd1);
        check("load_addr", mem_addr, 16'h0040);
        check("load_data", out_mem_data, 16'hBEEF);
        check("memwb_capture", memwb_q, 16'hBEEF);

        wb_write_reg = 1'b1; wb_dst_reg = 4'd5; wb_data = 16'h2222;
        run_instr("store fwd r5", 1, 0, 1, 0, 4'd5, 16'h0100, 16'h1111, 1, 16'h0000, 0, 0);
        check("fwd_wdata", mem_wdata, 16'h2222);
        check("fwd_used", 16'(fwd_used), 16'd1);
        check("fwd_we", 16'(mem_we), 16'd1);
        check("store_keeps_out", out_mem_data, 16'hBEEF);

        wb_dst_reg = 4'd0;
        run_instr("store wb r0", 1, 0, 1, 0, 4'd5, 16'h0102, 16'h1111, 0, 16'h0000, 0, 0);
        check("nofwd_wdata", mem_wdata, 16'h1111);
        check("nofwd_used", 16'(fwd_used), 16'd0);
        run_instr("store src r0", 1, 0, 1, 0, 4'd0, 16'h0104, 16'h1111, 0, 16'h0000, 0, 0);
        check("r0_wdata", mem_wdata, 16'h1111);
        wb_write_reg = 1'b0;

        run_instr("load delay5", 1, 1, 0, 0, 4'd2, 16'h0200, 16'h0000, 5, 16'h1234, 1, 0);
        check("delay_stall_cycles", 16'(stall_cnt), 16'd7);
        check("delay_req_cycles", 16'(req_cnt), 16'd6);
        check("delay_addr", mem_addr, 16'h0200);
        check("delay_data", out_mem_data, 16'h1234);

        run_instr("rd+wr as store", 1, 1, 1, 0, 4'd3, 16'h0300, 16'h5555, 0, 16'h9999, 0, 1);
        check("rdwr_we", 16'(mem_we), 16'd1);
        check("rdwr_keeps_out", out_mem_data, 16'h1234);

        run_instr("load timeout", 1, 1, 0, 0, 4'd1, 16'h0400, 16'h0000, -1, 16'h0000, 0, 0);
        check("to_req_cycles", 16'(req_cnt), 16'd64);
        check("to_stall_cycles", 16'(stall_cnt), 16'd65);
        check("to_err", 16'(mem_err), 16'd1);
        check("to_data", out_mem_data, 16'h0000);

        run_instr("load after err", 1, 1, 0, 0, 4'd1, 16'h0410, 16'h0000, 2, 16'hCAFE, 0, 0);
        check("err_sticky", 16'(mem_err), 16'd1);
        check("after_err_data", out_mem_data, 16'hCAFE);

        run_instr("load b2b", 1, 1, 0, 0, 4'd1, 16'h0500, 16'h0000, 0, 16'h0A0A, 0, 0);
        run_instr("alu op stray ack", 1, 0, 0, 0, 4'd1, 16'h0600, 16'h0000, 0, 16'h0000, 0, 1);
        check("alu_stall", 16'(stall_cnt), 16'd0);
        check("alu_req", 16'(req_cnt), 16'd0);
        run_instr("halt", 1, 1, 0, 1, 4'd1, 16'h0700, 16'h0000, 0, 16'h0000, 0, 1);
        check("halt_stall", 16'(stall_cnt), 16'd0);
        check("halt_req", 16'(req_cnt), 16'd0);
        check("b2b_data", out_mem_data, 16'h0A0A);

        // Reset during the 3rd REQ cycle of a load that never acks
        in_valid = 1; in_mem_read = 1; in_mem_write = 0; in_halt = 0;
        in_alu_out = 16'h0800; in_store_data = 16'h3333; in_src_reg2 = 4'd1;
        set_exp(1'b1, 1'b0);
        step();
        h_addr = 16'h0800; h_we = 1'b0; h_wdata = 16'h3333; h_fwd = 1'b0;
        repeat (2) begin
            set_exp(1'b1, 1'b1);
            step();
        end
        chk_en = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("arst_req", 16'(mem_req), 16'd0);
        check("arst_stall", 16'(stall), 16'd0);
        check("arst_addr", mem_addr, 16'h0000);
        check("arst_wdata", mem_wdata, 16'h0000);
        check("arst_out", out_mem_data, 16'h0000);
        check("arst_err", 16'(mem_err), 16'd0);
        in_valid = 1'b0;
        @(posedge clk); #3;
        rst = 1'b1;
        @(posedge clk); #1;
        h_we = 1'b0; h_fwd = 1'b0; h_err = 1'b0; h_addr = '0; h_wdata = '0; h_out = '0;
        chk_en = 1'b1;

        run_instr("idle after rst", 0, 0, 0, 0, 4'd0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0);
        check("post_rst_stall", 16'(stall_cnt), 16'd0);
        run_instr("load after rst", 1, 1, 0, 0, 4'd4, 16'h0900, 16'h0000, 0, 16'h7777, 0, 0);
        check("post_rst_data", out_mem_data, 16'h7777);
        check("post_rst_err", 16'(mem_err), 16'd0);
        check("post_rst_stall_cycles", 16'(stall_cnt), 16'd2);

        run_instr("ack on last cycle", 1, 1, 0, 0, 4'd4, 16'h0A00, 16'h0000, TO - 1, 16'h5A5A, 0, 0);
        check("last_ack_err", 16'(mem_err), 16'd0);
        check("last_ack_data", out_mem_data, 16'h5A5A);
        check("last_ack_req_cycles", 16'(req_cnt), 16'd64);

        chk_en = 1'b0;
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
